mem_map_ctrl: RTL

MEM_MAP_CTRL -- requirements
Module: mem_map_ctrl

---
 rtl/mem_map_pkg.sv | 28 ++
 rtl/mem_map_decoder.sv | 47 ++++
 rtl/mem_map_ctrl.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/mem_map_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_map_pkg
// Description : Shared FSM state type, default two-region memory map and
//               error-counter width for the memory-map controller.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_map_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    localparam int c_err_cnt_w = 16;

    // Region 0: ROM 0..152099 read-only; region 1: RAM 152100..304455 writable
    localparam logic [63:0] c_def_region_base  = {32'd152100, 32'd0};
    localparam logic [63:0] c_def_region_limit = {32'd304455, 32'd152099};
    localparam logic [1:0]  c_def_region_wr    = 2'b10;

    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_map_decoder.sv
`default_nettype none
// ============================================================================
// Module      : mem_map_decoder
// Description : Combinational address decoder: region hit, index, local
//               offset and writable flag; lowest index wins on overlap.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_map_decoder #(
    parameter int                             NUM_REGIONS  = 2,
    parameter int                             ADDR_W       = 32,
    parameter int                             IDX_W        = 1,
    parameter logic [NUM_REGIONS*ADDR_W-1:0]  REGION_BASE  = '0,
    parameter logic [NUM_REGIONS*ADDR_W-1:0]  REGION_LIMIT = '0,
    parameter logic [NUM_REGIONS-1:0]         REGION_WR    = '0
) (
    input  logic [ADDR_W-1:0] addr,
    output logic              hit,
    output logic [IDX_W-1:0]  idx,
    output logic [ADDR_W-1:0] offset,
    output logic              writable
);

    logic [ADDR_W-1:0] w_base;
    logic [ADDR_W-1:0] w_span;

    always_comb begin
        hit      = 1'b0;
        idx      = '0;
        offset   = '0;
        writable = 1'b0;
        w_base   = '0;
        w_span   = '0;
        // Walk downwards so the lowest matching index is the last one written
        for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
            w_base = REGION_BASE[i*ADDR_W +: ADDR_W];
            w_span = REGION_LIMIT[i*ADDR_W +: ADDR_W] - w_base;
            if ((addr - w_base) <= w_span) begin
                hit      = 1'b1;
                idx      = IDX_W'(i);
                offset   = addr - w_base;
                writable = REGION_WR[i];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_map_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mem_map_ctrl
// Description : Single-outstanding memory-map controller: decodes requests
//               into regions, runs the memory access and returns one response.
//               Optional fault counter enabled by MEM_MAP_ERR_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_map_ctrl
    import mem_map_pkg::*;
#(
    parameter int                             NUM_REGIONS  = 2,
    parameter int                             ADDR_W       = 32,
    parameter int                             DATA_W       = 32,
    parameter int                             RD_LAT       = 1,
    parameter logic [NUM_REGIONS*ADDR_W-1:0]  REGION_BASE  = c_def_region_base,
    parameter logic [NUM_REGIONS*ADDR_W-1:0]  REGION_LIMIT = c_def_region_limit,
    parameter logic [NUM_REGIONS-1:0]         REGION_WR    = c_def_region_wr
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 req_valid,
    output logic                                 req_ready,
    input  logic                                 req_we,
    input  logic [ADDR_W-1:0]                    req_addr,
    input  logic [DATA_W-1:0]                    req_wdata,
    output logic                                 rsp_valid,
    output logic [DATA_W-1:0]                    rsp_rdata,
    output logic                                 rsp_err,
    output logic [clog2_min1(NUM_REGIONS)-1:0]   rsp_region,
    output logic [NUM_REGIONS-1:0]               mem_sel,
    output logic                                 mem_we,
    output logic [ADDR_W-1:0]                    mem_addr,
    output logic [DATA_W-1:0]                    mem_wdata,
    input  logic [NUM_REGIONS*DATA_W-1:0]        mem_rdata
`ifdef MEM_MAP_ERR_CNT_EN
    ,
    output logic [c_err_cnt_w-1:0]               err_cnt
`endif
);

    localparam int c_idx_w = clog2_min1(NUM_REGIONS);
    localparam int c_cnt_w = clog2_min1(RD_LAT);

    state_t              r_state;
    state_t              w_next;
    logic                w_accept;
    logic                w_hit;
    logic                w_wr;
    logic                w_fault;
    logic [c_idx_w-1:0]  w_idx;
    logic [ADDR_W-1:0]   w_offset;
    logic [c_idx_w-1:0]  r_idx;
    logic                r_we;
    logic [DATA_W-1:0]   r_wdata;
    logic [c_cnt_w-1:0]  r_cnt;

    mem_map_decoder #(
        .NUM_REGIONS  (NUM_REGIONS),
        .ADDR_W       (ADDR_W),
        .IDX_W        (c_idx_w),
        .REGION_BASE  (REGION_BASE),
        .REGION_LIMIT (REGION_LIMIT),
        .REGION_WR    (REGION_WR)
    ) u_decoder (
        .addr     (req_addr),
        .hit      (w_hit),
        .idx      (w_idx),
        .offset   (w_offset),
        .writable (w_wr)
    );

    assign w_fault = !w_hit || (req_we && !w_wr);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (req_valid) begin
                    w_accept = 1'b1;
                    w_next   = w_fault ? ST_RESP : ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                // Writes take one cycle; reads hold for the full read latency
                if (r_we || (r_cnt == c_cnt_w'(RD_LAT - 1))) begin
                    w_next = ST_RESP;
                end
            end
            ST_RESP: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx      <= '0;
            r_we       <= 1'b0;
            r_wdata    <= '0;
            r_cnt      <= '0;
            mem_addr   <= '0;
            rsp_err    <= 1'b0;
            rsp_rdata  <= '0;
            rsp_region <= '0;
        end else begin
            if (w_accept) begin
                r_idx    <= w_idx;
                r_we     <= req_we;
                r_wdata  <= req_wdata;
                r_cnt    <= '0;
                mem_addr <= w_offset;
                if (w_fault) begin
                    rsp_err    <= 1'b1;
                    rsp_rdata  <= '0;
                    rsp_region <= w_idx;
                end
            end
            if (r_state == ST_ACCESS) begin
                r_cnt <= r_cnt + c_cnt_w'(1);
                if (w_next == ST_RESP) begin
                    rsp_err    <= 1'b0;
                    rsp_region <= r_idx;
                    rsp_rdata  <= r_we ? '0 : mem_rdata[int'(r_idx)*DATA_W +: DATA_W];
                end
            end
        end
    end

    assign req_ready = (r_state == ST_IDLE);
    assign rsp_valid = (r_state == ST_RESP);
    assign mem_sel   = (r_state == ST_ACCESS) ? (NUM_REGIONS'(1) << r_idx) : '0;
    assign mem_we    = (r_state == ST_ACCESS) && r_we;
    assign mem_wdata = r_wdata;

`ifdef MEM_MAP_ERR_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt <= '0;
        end else if ((r_state == ST_RESP) && rsp_err && (err_cnt != '1)) begin
            err_cnt <= err_cnt + c_err_cnt_w'(1);
        end
    end
`endif

endmodule
`default_nettype wire
